countdown_timer: RTL
====================

// Module: countdown_timer
// PURPOSE
//  Presettable countdown timer, the down-counting counterpart to the stopwatch.
//  Loads a whole-second preset from switches and counts down in centiseconds
//  on a divided 100 Hz tick. Start/pause is a single button.
//  Raises a timed alarm at zero. Outputs are binary seconds and centiseconds;
//  they feed the existing BCD conversion and 8-digit display path.
// PARAMETERS
//  CLK_HZ    100_000_000  input clock frequency
//  TICK_HZ   100          count rate (centisecond tick); DIV = CLK_HZ/TICK_HZ
//  MAX_SEC   99999        largest loadable preset in seconds; larger values clamp
//  ALARM_CS  500          alarm duration, in ticks, after expiry
// PORTS
//  clk      in   1   system clock
//  rst      in   1   synchronous reset, active-low
//  load     in   1   1-cycle pulse: load preset (already debounced upstream)
//  sp       in   1   1-cycle pulse: start/pause/acknowledge (already debounced)
//  preset   in   17  preset in whole seconds
//  seconds  out  17  remaining whole seconds
//  csec     out  7   remaining centiseconds, 0..99
//  running  out  1   high in RUN
//  expired  out  1   high in EXPIRED
//  alarm    out  1   high for ALARM_CS ticks after reaching zero
// BEHAVIOUR
//  - rst=0 at posedge: state IDLE, seconds=0, csec=0, prescaler=0, alarm count=0.
//    All outputs are 0. Reset overrides all inputs.
//  - All outputs are registered. They change on the same edge that samples the causing event.
//  - Prescaler: counts 0..DIV-1 in RUN and EXPIRED and holds in IDLE/PAUSE.
//    tick = 1 cycle when prescaler==DIV-1; the prescaler then wraps to 0.
//    Load clears it, and so does sp in IDLE. PAUSE keeps the fractional tick.
//  - Remaining time is kept as separate {seconds,csec} registers, with no divider.
//    Decrement: if csec==0 then csec<=99, seconds<=seconds-1; else csec<=csec-1.
//  - Priority per edge: rst > load > sp > tick.
//  - load (any state): seconds<=min(preset,MAX_SEC), csec<=0, alarm<=0, state IDLE.
//    An sp in the same cycle is ignored.
//  - IDLE:    sp and (seconds|csec)!=0 -> RUN; sp with zero time -> stay IDLE.
//  - RUN:     sp -> PAUSE with no decrement that cycle, even if tick coincides.
//             tick -> decrement. If the value is 0/01 at tick, it becomes 0/00,
//             state goes to EXPIRED, alarm<=1 and alarm count<=0 on that same edge.
//  - PAUSE:   sp -> RUN; the time value is frozen.
//  - EXPIRED: time holds 0/00. On each tick the alarm count increments.
//             alarm drops on the edge where the count reaches ALARM_CS.
//             sp -> IDLE with alarm<=0, at any time during or after the alarm.
//  - The count never wraps below 0/00. An sp with zero time never enters RUN.
//  - Internal widths: prescaler is clog2(DIV); alarm count is clog2(ALARM_CS+1).
// TESTING  (bench params CLK_HZ=1000, TICK_HZ=100 -> DIV=10, ALARM_CS=5)
//  1 rst=0 for 2 cycles with load/sp active -> all outputs 0, state IDLE.
//  2 preset=3, load, sp -> first tick gives 2/99. After 300 ticks: 0/00,
//    expired=1, running=0, alarm=1.
//  3 preset=5, run 150 ticks, sp, wait 2000 cycles -> holds 3/50.
//    sp again -> next tick at the remaining prescaler phase gives 3/49.
//  4 preset=120000, load -> seconds=99999, csec=0. load while RUN -> IDLE with new preset.
//  5 load and sp in the same cycle -> IDLE, running=0. sp coinciding with tick in RUN -> PAUSE, no decrement.
//  6 after expiry: alarm high exactly 5 ticks then low. sp -> IDLE, expired=0.
//    A further sp -> stays IDLE (zero time).

Source files
------------

// File: rtl/countdown_timer.sv
// Presettable centisecond countdown timer with start/pause button and a timed alarm at zero.
// Remaining time is held as separate binary {seconds, csec} registers for the BCD display path.
module countdown_timer #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 100,
  parameter int MAX_SEC  = 99999,
  parameter int ALARM_CS = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        sp,
  input  logic [16:0] preset,
  output logic [16:0] seconds,
  output logic [6:0]  csec,
  output logic        running,
  output logic        expired,
  output logic        alarm
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(ALARM_CS + 1);
  localparam logic [PW-1:0] PRE_LAST   = PW'(DIV - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_CS);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [AW-1:0] alarm_cnt;
  logic          tick;

  function automatic logic [16:0] clamp_sec(input logic [16:0] p);
    return (p > 17'(MAX_SEC)) ? 17'(MAX_SEC) : p;
  endfunction

  // The prescaler only advances in RUN and EXPIRED, so a pause keeps the partial tick.
  assign tick = ((state == RUN) || (state == EXPIRED)) && (presc == PRE_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      seconds   <= '0;
      csec      <= '0;
      presc     <= '0;
      alarm_cnt <= '0;
      running   <= 1'b0;
      expired   <= 1'b0;
      alarm     <= 1'b0;
    end else if (load) begin
      state     <= IDLE;
      seconds   <= clamp_sec(preset);
      csec      <= '0;
      presc     <= '0;
      alarm_cnt <= '0;
      running   <= 1'b0;
      expired   <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      if ((state == RUN) || (state == EXPIRED))
        presc <= tick ? '0 : presc + 1'b1;
      case (state)
        IDLE: begin
          if (sp) begin
            presc <= '0;
            if ((seconds != '0) || (csec != '0)) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
        end
        RUN: begin
          if (sp) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (tick) begin
            if (csec == '0) begin
              csec    <= 7'd99;
              seconds <= seconds - 1'b1;
            end else begin
              csec <= csec - 1'b1;
              // Reaching 0/00 expires on the same edge; the count never wraps below zero.
              if ((seconds == '0) && (csec == 7'd1)) begin
                state     <= EXPIRED;
                running   <= 1'b0;
                expired   <= 1'b1;
                alarm     <= 1'b1;
                alarm_cnt <= '0;
              end
            end
          end
        end
        PAUSE: begin
          if (sp) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        EXPIRED: begin
          if (sp) begin
            state   <= IDLE;
            expired <= 1'b0;
            alarm   <= 1'b0;
          end else if (tick && alarm) begin
            alarm_cnt <= alarm_cnt + 1'b1;
            if ((alarm_cnt + AW'(1)) == ALARM_LAST)
              alarm <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
